// File: rtl/btle_tx_framer_if.sv
// Octet-memory read port between the BLE TX framer (master) and its PDU store (slave).
interface btle_tx_framer_if #(
  parameter int MEM_ADDR_WIDTH = 6
);
  logic                      mem_rd_en;
  logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr;
  logic [7:0]                mem_rd_data;

  modport master (output mem_rd_en, output mem_rd_addr, input mem_rd_data);
  modport slave  (input mem_rd_en, input mem_rd_addr, output mem_rd_data);
endinterface

// File: rtl/btle_tx_framer.sv
// BLE TX bit-stream framer: preamble + AA + whitened PDU + whitened CRC24, LE 1M/2M.
// Optional abort input enabled by defining BTLE_TX_FRAMER_ABORT_EN.
module btle_tx_framer #(
  parameter int         CLK_PER_BIT              = 16,
  parameter int         MAX_PDU_OCTETS           = 64,
  parameter int         MEM_ADDR_WIDTH           = 6,
  parameter logic [7:0] LENGTH_MASK              = 8'hFF,
  parameter int         CRC_STATE_BIT_WIDTH      = 24,
  parameter int         CHANNEL_NUMBER_BIT_WIDTH = 6
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                phy_2m,
  input  logic [7:0]                          preamble,
  input  logic [31:0]                         access_address,
  input  logic [CRC_STATE_BIT_WIDTH-1:0]      crc_state_init,
  input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
  input  logic                                tx_start,
`ifdef BTLE_TX_FRAMER_ABORT_EN
  input  logic                                tx_abort,
`endif
  btle_tx_framer_if.master                    mem,
  output logic                                phy_bit,
  output logic                                phy_bit_valid,
  output logic                                phy_bit_valid_last,
  output logic                                busy,
  output logic                                done,
  output logic                                len_err
);
  localparam int CW   = $clog2(CLK_PER_BIT);
  localparam int CRCW = CRC_STATE_BIT_WIDTH;
  localparam int LW   = ((MEM_ADDR_WIDTH > 8) ? MEM_ADDR_WIDTH : 8) + 2;
  localparam logic [CRCW-1:0] CRC_POLY = CRCW'(24'h00065B);
  localparam logic [7:0]      MAX_LEN  = 8'(MAX_PDU_OCTETS - 2);
  localparam logic [5:0]      CRC_LAST = 6'(CRCW - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE_AA, S_HEADER, S_PAYLOAD, S_CRC, S_DONE} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]             cnt_q, cnt_d, pmax;
  logic [5:0]                bit_cnt_q, bit_cnt_d;
  logic [MEM_ADDR_WIDTH-1:0] oct_idx_q, oct_idx_d, rd_addr_q, rd_addr_d;
  logic [7:0]                len_q, len_d, oct_q, oct_d, nxt_q, nxt_d;
  logic [47:0]               pa_q, pa_d;
  logic [CRCW-1:0]           crc_q, crc_d, crc_step;
  logic [6:0]                w_q, w_d, w_step, w_seed;
  logic                      len_err_q, len_err_d, phy2m_q, phy2m_d, phy_bit_q, phy_bit_d;
  logic                      rd_en_q, rd_en_d, rd_pend_q, rd_pend_d;
  logic                      busy_st, tick, accept, pre_done, oct_end, last_oct, crc_done, cur_bit, fb;
  logic [7:0]                len_raw, len_clamp;
  logic [LW-1:0]             idx_w, len_w;

  assign busy_st   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign pmax      = phy2m_q ? CW'(CLK_PER_BIT/2 - 1) : CW'(CLK_PER_BIT - 1);
  assign tick      = busy_st && (cnt_q == pmax);
  assign accept    = (state_q == S_IDLE) && tx_start;
  assign pre_done  = (state_q == S_PRE_AA) && tick && (bit_cnt_q == (phy2m_q ? 6'd47 : 6'd39));
  assign oct_end   = ((state_q == S_HEADER) || (state_q == S_PAYLOAD)) && tick && (bit_cnt_q == 6'd7);
  assign crc_done  = (state_q == S_CRC) && tick && (bit_cnt_q == CRC_LAST);
  // Length octet sits in nxt_q while octet 0 is on air, so it is clamped on the fly there.
  assign len_raw   = nxt_q & LENGTH_MASK;
  assign len_clamp = (len_raw > MAX_LEN) ? MAX_LEN : len_raw;
  assign idx_w     = LW'(oct_idx_q);
  assign len_w     = LW'((oct_idx_q == '0) ? len_clamp : len_q);
  assign last_oct  = (oct_idx_q != '0) && (idx_w == len_w + LW'(1));

  // CRC24 Galois step on the raw PDU bit; whitening is x^7+x^4+1 with output at position 6.
  assign fb       = oct_q[0] ^ crc_q[CRCW-1];
  assign crc_step = {crc_q[CRCW-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  assign w_step   = {w_q[5], w_q[4], w_q[3] ^ w_q[6], w_q[2], w_q[1], w_q[0], w_q[6]};
  assign w_seed   = {channel_number[0], channel_number[1], channel_number[2],
                     channel_number[3], channel_number[4], channel_number[5], 1'b1};

  always_comb begin
    cur_bit = 1'b0;
    case (state_q)
      S_PRE_AA:            cur_bit = pa_q[0];
      S_HEADER, S_PAYLOAD: cur_bit = oct_q[0] ^ w_q[6];
      S_CRC:               cur_bit = crc_q[CRCW-1] ^ w_q[6];
      default:             cur_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (tx_start) state_d = S_PRE_AA;
      S_PRE_AA:  if (pre_done) state_d = S_HEADER;
      S_HEADER:  if (oct_end) state_d = last_oct ? S_CRC : ((oct_idx_q == '0) ? S_HEADER : S_PAYLOAD);
      S_PAYLOAD: if (oct_end && last_oct) state_d = S_CRC;
      S_CRC:     if (crc_done) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
`ifdef BTLE_TX_FRAMER_ABORT_EN
    if (busy_st && tx_abort) state_d = S_DONE;
`endif
  end

  always_comb begin
    busy               = busy_st;
    done               = (state_q == S_DONE);
    phy_bit_valid      = tick;
    phy_bit_valid_last = crc_done;
    phy_bit            = phy_bit_q;
    len_err            = len_err_q;
  end

  assign mem.mem_rd_en   = rd_en_q;
  assign mem.mem_rd_addr = rd_addr_q;

  always_comb begin
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    oct_idx_d = oct_idx_q;
    len_d     = len_q;
    len_err_d = len_err_q;
    phy2m_d   = phy2m_q;
    pa_d      = pa_q;
    oct_d     = oct_q;
    nxt_d     = rd_pend_q ? mem.mem_rd_data : nxt_q;
    crc_d     = crc_q;
    w_d       = w_q;
    phy_bit_d = phy_bit_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_pend_d = rd_en_q;
    if (accept) begin
      cnt_d     = '0;
      bit_cnt_d = '0;
      len_err_d = 1'b0;
      phy2m_d   = phy_2m;
      pa_d      = phy_2m ? {access_address, preamble, preamble} : {8'h00, access_address, preamble};
      crc_d     = crc_state_init;
      w_d       = w_seed;
      rd_en_d   = 1'b1;
      rd_addr_d = '0;
    end else if (busy_st) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      // Present the bit one clk ahead of its strobe; it then holds for the whole period.
      if (cnt_q == pmax - 1'b1) phy_bit_d = cur_bit;
      if (tick) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        case (state_q)
          S_PRE_AA: begin
            pa_d = pa_q >> 1;
            if (pre_done) begin
              bit_cnt_d = '0;
              oct_d     = nxt_q;
              oct_idx_d = '0;
              rd_en_d   = 1'b1;
              rd_addr_d = MEM_ADDR_WIDTH'(1);
            end
          end
          S_HEADER, S_PAYLOAD: begin
            crc_d = crc_step;
            w_d   = w_step;
            oct_d = oct_q >> 1;
            if (oct_end) begin
              bit_cnt_d = '0;
              if (!last_oct) begin
                oct_d     = nxt_q;
                oct_idx_d = oct_idx_q + 1'b1;
                if (oct_idx_q == '0) begin
                  len_d     = len_clamp;
                  len_err_d = len_err_q | (len_raw > MAX_LEN);
                end
                if (idx_w + LW'(2) <= len_w + LW'(1)) begin
                  rd_en_d   = 1'b1;
                  rd_addr_d = MEM_ADDR_WIDTH'(idx_w + LW'(2));
                end
              end
            end
          end
          S_CRC: begin
            crc_d = {crc_q[CRCW-2:0], 1'b0};
            w_d   = w_step;
          end
          default: ;
        endcase
      end
    end else if (state_q == S_DONE) begin
      phy_bit_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      oct_idx_q <= '0;
      len_q     <= '0;
      len_err_q <= 1'b0;
      phy2m_q   <= 1'b0;
      pa_q      <= '0;
      oct_q     <= '0;
      nxt_q     <= '0;
      crc_q     <= '0;
      w_q       <= '0;
      phy_bit_q <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      oct_idx_q <= oct_idx_d;
      len_q     <= len_d;
      len_err_q <= len_err_d;
      phy2m_q   <= phy2m_d;
      pa_q      <= pa_d;
      oct_q     <= oct_d;
      nxt_q     <= nxt_d;
      crc_q     <= crc_d;
      w_q       <= w_d;
      phy_bit_q <= phy_bit_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rd_pend_q <= rd_pend_d;
    end
  end
endmodule

// File: tb/tb_btle_tx_framer.sv
// Directed bench for btle_tx_framer: 1M/2M frames, length clamp, ignored start, reset, abort.
module tb_btle_tx_framer;
  localparam int CPB = 16;

  logic        clk = 1'b0, rst = 1'b1, phy_2m = 1'b0, tx_start = 1'b0;
  logic [7:0]  preamble = 8'hAA;
  logic [31:0] aa = 32'h8E89BED6;
  logic [23:0] crc_init = 24'h555555;
  logic [5:0]  chan = 6'd37;
  logic        phy_bit, vld, vlast, busy, done, len_err;
`ifdef BTLE_TX_FRAMER_ABORT_EN
  logic        tx_abort = 1'b0;
`endif

  btle_tx_framer_if #(.MEM_ADDR_WIDTH(6)) mif ();

  btle_tx_framer dut (
    .clk(clk), .rst(rst), .phy_2m(phy_2m), .preamble(preamble), .access_address(aa),
    .crc_state_init(crc_init), .channel_number(chan), .tx_start(tx_start),
`ifdef BTLE_TX_FRAMER_ABORT_EN
    .tx_abort(tx_abort),
`endif
    .mem(mif), .phy_bit(phy_bit), .phy_bit_valid(vld), .phy_bit_valid_last(vlast),
    .busy(busy), .done(done), .len_err(len_err)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [64];
  always @(posedge clk) if (mif.mem_rd_en) mif.mem_rd_data <= mem[mif.mem_rd_addr];

  logic [7:0] outs;
  assign outs = {busy, done, vld, vlast, phy_bit, len_err, mif.mem_rd_en, |mif.mem_rd_addr};

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  bit obs_q[$], exp_q[$];
  int nv, first_k, last_k, bad_sp, nlast, last_at, done_k, nrd, max_addr;
  int busy1, lerr1, busy_done, got_done;
  int mid_bit = -1, rst_bit = -1, abort_bit = -1;

  task automatic run_frame(input logic m2);
    int k, p;
    bit fin, hit_rst;
    p = m2 ? CPB/2 : CPB;
    obs_q.delete();
    nv = 0; first_k = -1; last_k = 0; bad_sp = 0; nlast = 0; last_at = -1; done_k = -1;
    nrd = 0; max_addr = 0; busy1 = 0; lerr1 = 0; busy_done = -1; got_done = 0;
    fin = 0; hit_rst = 0; k = 0;
    @(negedge clk);
    phy_2m = m2; tx_start = 1'b1;
    while (!fin) begin
      @(negedge clk);
      k++;
      tx_start = 1'b0;
`ifdef BTLE_TX_FRAMER_ABORT_EN
      tx_abort = 1'b0;
`endif
      if (hit_rst) begin
        chk("rst_outs_zero", int'(outs), 0);
        rst = 1'b0;
        fin = 1;
      end else begin
        if (k == 1) begin busy1 = int'(busy); lerr1 = int'(len_err); end
        if (mif.mem_rd_en) begin
          nrd++;
          if (int'(mif.mem_rd_addr) > max_addr) max_addr = int'(mif.mem_rd_addr);
        end
        if (vld) begin
          obs_q.push_back(phy_bit);
          if (nv == 0) first_k = k;
          else if (k - last_k != p) bad_sp++;
          last_k = k;
          nv++;
          if (vlast) begin nlast++; last_at = nv; end
          if (nv == mid_bit) begin tx_start = 1'b1; chan = ~chan; end
          if (nv == rst_bit) begin rst = 1'b1; hit_rst = 1; end
`ifdef BTLE_TX_FRAMER_ABORT_EN
          if (nv == abort_bit) tx_abort = 1'b1;
`endif
        end
        if (done) begin got_done = 1; done_k = k; busy_done = int'(busy); fin = 1; end
        if (k >= 20000) begin chk("frame_timeout", k, 0); fin = 1; end
      end
    end
  endtask

  task automatic build_exp(input logic m2, input int len);
    bit c[24];
    bit w[7];
    bit d, fb, t;
    exp_q.delete();
    for (int r = 0; r < (m2 ? 2 : 1); r++)
      for (int i = 0; i < 8; i++) exp_q.push_back(preamble[i]);
    for (int i = 0; i < 32; i++) exp_q.push_back(aa[i]);
    for (int i = 0; i < 24; i++) c[i] = crc_init[i];
    w[0] = 1'b1;
    for (int i = 1; i < 7; i++) w[i] = chan[6-i];
    for (int o = 0; o < len + 2; o++) begin
      for (int i = 0; i < 8; i++) begin
        d  = mem[o][i];
        fb = d ^ c[23];
        for (int q = 23; q > 0; q--) c[q] = c[q-1];
        c[0] = fb; c[1] ^= fb; c[3] ^= fb; c[4] ^= fb; c[6] ^= fb; c[9] ^= fb; c[10] ^= fb;
        exp_q.push_back(d ^ w[6]);
        t = w[6];
        for (int q = 6; q > 0; q--) w[q] = w[q-1];
        w[0] = t; w[4] ^= t;
      end
    end
    for (int q = 23; q >= 0; q--) begin
      exp_q.push_back(c[q] ^ w[6]);
      t = w[6];
      for (int r = 6; r > 0; r--) w[r] = w[r-1];
      w[0] = t; w[4] ^= t;
    end
  endtask

  task automatic check_frame(input string tag, input logic m2, input int len);
    int nmis;
    build_exp(m2, len);
    nmis = 0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] != exp_q[i]) nmis++;
    chk({tag, "_accepted"}, busy1, 1);
    chk({tag, "_nbits"}, nv, exp_q.size());
    chk({tag, "_first_valid_clk"}, first_k, m2 ? CPB/2 : CPB);
    chk({tag, "_spacing_errs"}, bad_sp, 0);
    chk({tag, "_bit_mismatches"}, nmis, 0);
    chk({tag, "_last_count"}, nlast, 1);
    chk({tag, "_last_pos"}, last_at, exp_q.size());
    chk({tag, "_done_clk"}, done_k, last_k + 1);
    chk({tag, "_busy_at_done"}, busy_done, 0);
    chk({tag, "_reads"}, nrd, len + 2);
    chk({tag, "_max_addr"}, max_addr, len + 1);
  endtask

  initial begin
    int quiet;
    logic [15:0] pre16;
    logic [31:0] aa32;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'h40; mem[1] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outs", int'(outs), 0);
    rst = 1'b0;

    run_frame(1'b0);
    check_frame("1m", 1'b0, 0);
    for (int i = 0; i < 8; i++) pre16[i] = obs_q[i];
    for (int i = 0; i < 32; i++) aa32[i] = obs_q[8+i];
    chk("1m_preamble", int'(pre16[7:0]), 8'hAA);
    chk("1m_access_addr", int'(aa32), int'(32'h8E89BED6));

    run_frame(1'b1);
    check_frame("2m", 1'b1, 0);
    for (int i = 0; i < 16; i++) pre16[i] = obs_q[i];
    chk("2m_preamble_x2", int'(pre16), 16'hAAAA);

    mem[0] = 8'h02; mem[1] = 8'd200;
    run_frame(1'b0);
    check_frame("clamp", 1'b0, 62);
    chk("len_err_set", int'(len_err), 1);

    // Back-to-back after the clamped frame; a second start lands mid-payload.
    mem[1] = 8'd5;
    mid_bit = 60;
    run_frame(1'b0);
    mid_bit = -1;
    chan = 6'd37;
    chk("len_err_cleared", lerr1, 0);
    check_frame("mid_start", 1'b0, 5);

    run_frame(1'b0);
    check_frame("b2b", 1'b0, 5);

    rst_bit = 50;
    run_frame(1'b0);
    rst_bit = -1;
    chk("rst_nbits", nv, 50);
    quiet = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy || vld) quiet++;
    end
    chk("rst_no_done", quiet, 0);
    run_frame(1'b0);
    check_frame("post_rst", 1'b0, 5);

`ifdef BTLE_TX_FRAMER_ABORT_EN
    abort_bit = 60;
    run_frame(1'b0);
    abort_bit = -1;
    chk("abort_nbits", nv, 60);
    chk("abort_no_last", nlast, 0);
    chk("abort_done", got_done, 1);
    chk("abort_done_clk", done_k, last_k + 1);
    chk("abort_busy", busy_done, 0);
    quiet = 0;
    repeat (200) begin
      @(negedge clk);
      if (done || busy || vld || vlast) quiet++;
    end
    chk("abort_quiet", quiet, 0);
    run_frame(1'b0);
    check_frame("post_abort", 1'b0, 5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
